// File: rtl/dso_ui_pkg.sv
// dso_ui_pkg: shared types, reset values and lookup data for the DSO front-panel controller.
package dso_ui_pkg;

   typedef enum logic [1:0] {
      MODE_LEVEL  = 2'd0,
      MODE_EDGE   = 2'd1,
      MODE_DECI   = 2'd2,
      MODE_VSCALE = 2'd3
   } mode_t;

   localparam logic        RST_WAVE_RUN   = 1'b1;
   localparam logic [7:0]  RST_TRIG_LEVEL = 8'd127;
   localparam logic        RST_TRIG_EDGE  = 1'b1;
   localparam logic [9:0]  RST_DECI_RATE  = 10'd1;
   localparam logic [2:0]  RST_VS_IDX     = 3'd3;
   localparam mode_t       RST_SEL_MODE   = MODE_LEVEL;

   localparam logic [7:0]  LEVEL_STEP     = 8'd4;
   localparam logic [7:0]  LEVEL_MAX      = 8'd255;
   localparam logic [9:0]  DECI_MAX       = 10'd512;
   localparam logic [9:0]  DECI_MIN       = 10'd1;
   localparam logic [2:0]  VS_IDX_MAX     = 3'd6;

   // v_scale code per index: bit4 = zoom-in, [3:0] = factor
   function automatic logic [4:0] vscale_lut(input logic [2:0] idx);
      logic [4:0] code;
      case (idx)
         3'd0:    code = 5'b0_0100;
         3'd1:    code = 5'b0_0010;
         3'd2:    code = 5'b1_0001;
         3'd3:    code = 5'b1_0010;
         3'd4:    code = 5'b1_0100;
         3'd5:    code = 5'b1_1000;
         default: code = 5'b1_1111;
      endcase
      return code;
   endfunction

   localparam logic [4:0]  RST_V_SCALE    = vscale_lut(RST_VS_IDX);

   // milliseconds to clock cycles; 64-bit product avoids overflow at 50 MHz
   function automatic int unsigned ms_to_cycles(input longint unsigned ms,
                                                input longint unsigned fs);
      return 32'((ms * fs) / 64'd1000);
   endfunction

endpackage

// File: rtl/dso_ui_ctrl_key_debounce.sv
// key_debounce: 2-flop synchronizer, stability counter and press pulse for one active-low key.
module key_debounce #(
   parameter int unsigned DB_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic level,
   output logic press
);

   localparam int unsigned CW = $clog2(DB_CYC + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          armed;

   // Synchronizer flops reset to the pressed value so a key held through reset
   // never arms; arming needs a released sample after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         level <= 1'b1;
         cnt   <= '0;
         armed <= 1'b0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], key_raw};
         press <= 1'b0;
         if (sync[1]) armed <= 1'b1;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DB_CYC - 1)) begin
            cnt   <= '0;
            level <= sync[1];
            press <= armed & level;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/dso_ui_ctrl.sv
// dso_ui_ctrl: front-panel key handling and acquisition parameter registers.
// Optional auto-repeat on up/down keys: define DSO_UI_AUTOREPEAT_EN.
module dso_ui_ctrl
   import dso_ui_pkg::*;
#(
   parameter int unsigned CLK_FS      = 50_000_000,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned REPEAT_MS   = 200
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       key_run,
   input  logic       key_mode,
   input  logic       key_up,
   input  logic       key_down,
   output logic       wave_run,
   output logic [7:0] trig_level,
   output logic       trig_edge,
   output logic [9:0] deci_rate,
   output logic [4:0] v_scale,
   output logic [1:0] sel_mode,
   output logic       param_chg
);

   localparam int unsigned DB_CYC = ms_to_cycles(DEBOUNCE_MS, CLK_FS);

   logic [3:0] key_lvl;
   logic       run_press, mode_press, up_press, down_press;
   logic       up_evt, down_evt, step_up, step_dn, chg;
   mode_t      mode_q, n_mode;
   logic [2:0] vs_idx, n_vidx;
   logic       n_run, n_edge;
   logic [7:0] n_level;
   logic [9:0] n_deci;

   key_debounce #(.DB_CYC(DB_CYC)) u_db_run (
      .clk(sys_clk), .rst_n(sys_rst_n), .key_raw(key_run),  .level(key_lvl[0]), .press(run_press));
   key_debounce #(.DB_CYC(DB_CYC)) u_db_mode (
      .clk(sys_clk), .rst_n(sys_rst_n), .key_raw(key_mode), .level(key_lvl[1]), .press(mode_press));
   key_debounce #(.DB_CYC(DB_CYC)) u_db_up (
      .clk(sys_clk), .rst_n(sys_rst_n), .key_raw(key_up),   .level(key_lvl[2]), .press(up_press));
   key_debounce #(.DB_CYC(DB_CYC)) u_db_down (
      .clk(sys_clk), .rst_n(sys_rst_n), .key_raw(key_down), .level(key_lvl[3]), .press(down_press));

`ifdef DSO_UI_AUTOREPEAT_EN
   localparam int unsigned RP_CYC = ms_to_cycles(REPEAT_MS, CLK_FS);
   localparam int unsigned RW     = $clog2(RP_CYC + 1);

   logic [1:0]    rep_act, rep_pls, ud_press, ud_lvl;
   logic [RW-1:0] rep_cnt [2];

   assign ud_press = {down_press, up_press};
   assign ud_lvl   = key_lvl[3:2];

   // Repeat timers run only after a genuine press and stop on debounced release
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rep_act    <= '0;
         rep_pls    <= '0;
         rep_cnt[0] <= '0;
         rep_cnt[1] <= '0;
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            rep_pls[i] <= 1'b0;
            if (ud_press[i]) begin
               rep_act[i] <= 1'b1;
               rep_cnt[i] <= '0;
            end else if (!rep_act[i] || ud_lvl[i]) begin
               rep_act[i] <= 1'b0;
               rep_cnt[i] <= '0;
            end else if (rep_cnt[i] == RW'(RP_CYC - 1)) begin
               rep_cnt[i] <= '0;
               rep_pls[i] <= 1'b1;
            end else begin
               rep_cnt[i] <= rep_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign up_evt   = up_press   | (rep_pls[0] & (mode_q != MODE_EDGE));
   assign down_evt = down_press | (rep_pls[1] & (mode_q != MODE_EDGE));
`else
   assign up_evt   = up_press;
   assign down_evt = down_press;
`endif

   assign step_up  = up_evt & ~down_evt;
   assign step_dn  = down_evt & ~up_evt;
   assign sel_mode = mode_q;

   // Next parameter values; up/down act on the mode held before any mode event this cycle
   always_comb begin
      n_run   = wave_run;
      n_level = trig_level;
      n_edge  = trig_edge;
      n_deci  = deci_rate;
      n_vidx  = vs_idx;
      n_mode  = mode_q;
      if (run_press)  n_run  = ~wave_run;
      if (mode_press) n_mode = mode_t'(mode_q + 2'd1);
      case (mode_q)
         MODE_LEVEL: begin
            if (step_up)
               n_level = (trig_level > LEVEL_MAX - LEVEL_STEP) ? LEVEL_MAX : trig_level + LEVEL_STEP;
            else if (step_dn)
               n_level = (trig_level < LEVEL_STEP) ? '0 : trig_level - LEVEL_STEP;
         end
         MODE_EDGE: begin
            if (step_up || step_dn) n_edge = ~trig_edge;
         end
         MODE_DECI: begin
            if (step_up && deci_rate != DECI_MAX)      n_deci = deci_rate << 1;
            else if (step_dn && deci_rate != DECI_MIN) n_deci = deci_rate >> 1;
         end
         MODE_VSCALE: begin
            if (step_up && vs_idx != VS_IDX_MAX) n_vidx = vs_idx + 3'd1;
            else if (step_dn && vs_idx != '0)    n_vidx = vs_idx - 3'd1;
         end
         default: ;
      endcase
      chg = (n_run != wave_run) | (n_level != trig_level) | (n_edge != trig_edge) |
            (n_deci != deci_rate) | (n_vidx != vs_idx) | (n_mode != mode_q);
   end

   // Registered outputs with change strobe aligned to the update
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wave_run   <= RST_WAVE_RUN;
         trig_level <= RST_TRIG_LEVEL;
         trig_edge  <= RST_TRIG_EDGE;
         deci_rate  <= RST_DECI_RATE;
         vs_idx     <= RST_VS_IDX;
         v_scale    <= RST_V_SCALE;
         mode_q     <= RST_SEL_MODE;
         param_chg  <= 1'b0;
      end else begin
         wave_run   <= n_run;
         trig_level <= n_level;
         trig_edge  <= n_edge;
         deci_rate  <= n_deci;
         vs_idx     <= n_vidx;
         v_scale    <= vscale_lut(n_vidx);
         mode_q     <= n_mode;
         param_chg  <= chg;
      end
   end

endmodule

// File: tb/tb_dso_ui_ctrl.sv
// tb_dso_ui_ctrl: randomized and directed key stimulus against a behavioural panel model.
// CLK_FS=1000 makes one clock cycle equal one millisecond.
`timescale 1ns/1ps
module tb_dso_ui_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_run = 1'b1, key_mode = 1'b1, key_up = 1'b1, key_down = 1'b1;
   logic       wave_run, trig_edge, param_chg;
   logic [7:0] trig_level;
   logic [9:0] deci_rate;
   logic [4:0] v_scale;
   logic [1:0] sel_mode;

   dso_ui_ctrl #(.CLK_FS(1000), .DEBOUNCE_MS(20), .REPEAT_MS(200)) dut (
      .sys_clk(clk), .sys_rst_n(rst_n),
      .key_run(key_run), .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
      .wave_run(wave_run), .trig_level(trig_level), .trig_edge(trig_edge),
      .deci_rate(deci_rate), .v_scale(v_scale), .sel_mode(sel_mode), .param_chg(param_chg));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Behavioural model of the panel state
   int m_run, m_level, m_edge, m_deci, m_vidx, m_mode;
   int vtab [7] = '{4, 2, 17, 18, 20, 24, 31};

   task automatic model_reset();
      m_run = 1; m_level = 127; m_edge = 1; m_deci = 1; m_vidx = 3; m_mode = 0;
   endtask

   task automatic model_step(input bit r, input bit m, input bit u, input bit d, output bit chg);
      int old_mode;
      chg = 0;
      old_mode = m_mode;
      if (r) begin m_run = 1 - m_run; chg = 1; end
      if (m) begin m_mode = (m_mode + 1) % 4; chg = 1; end
      if (u != d) begin
         case (old_mode)
            0: begin
               int nl;
               nl = u ? ((m_level + 4 > 255) ? 255 : m_level + 4)
                      : ((m_level - 4 < 0) ? 0 : m_level - 4);
               if (nl != m_level) chg = 1;
               m_level = nl;
            end
            1: begin m_edge = 1 - m_edge; chg = 1; end
            2: begin
               int nd;
               nd = u ? ((m_deci * 2 > 512) ? 512 : m_deci * 2)
                      : ((m_deci / 2 < 1) ? 1 : m_deci / 2);
               if (nd != m_deci) chg = 1;
               m_deci = nd;
            end
            default: begin
               int ni;
               ni = u ? ((m_vidx < 6) ? m_vidx + 1 : 6) : ((m_vidx > 0) ? m_vidx - 1 : 0);
               if (ni != m_vidx) chg = 1;
               m_vidx = ni;
            end
         endcase
      end
   endtask

   // Every output change must coincide with exactly one param_chg cycle
   bit          mon_en = 0, have_prev = 0;
   logic [26:0] mon_cur, mon_prev;
   int          pulses = 0;

   always @(negedge clk) begin
      mon_cur = {wave_run, trig_level, trig_edge, deci_rate, v_scale, sel_mode};
      if (!mon_en) begin
         have_prev = 0;
      end else begin
         if (param_chg) pulses++;
         if (have_prev && ((mon_cur != mon_prev) || param_chg))
            check("chg_pulse", int'(param_chg), int'(mon_cur != mon_prev));
         mon_prev  = mon_cur;
         have_prev = 1;
      end
   end

   task automatic compare_all(input string tag);
      check({tag, "_run"},   int'(wave_run),   m_run);
      check({tag, "_level"}, int'(trig_level), m_level);
      check({tag, "_edge"},  int'(trig_edge),  m_edge);
      check({tag, "_deci"},  int'(deci_rate),  m_deci);
      check({tag, "_vscale"}, int'(v_scale),   vtab[m_vidx]);
      check({tag, "_mode"},  int'(sel_mode),   m_mode);
   endtask

   task automatic do_reset(input bit keep_keys);
      mon_en = 0;
      rst_n  = 1'b0;
      if (!keep_keys) begin
         key_run = 1'b1; key_mode = 1'b1; key_up = 1'b1; key_down = 1'b1;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1;
      model_reset();
   endtask

   task automatic do_press(input bit r, input bit m, input bit u, input bit d,
                           input int hold, input string tag);
      int p0;
      bit chg;
      p0 = pulses;
      @(negedge clk);
      key_run = ~r; key_mode = ~m; key_up = ~u; key_down = ~d;
      repeat (hold) @(negedge clk);
      key_run = 1'b1; key_mode = 1'b1; key_up = 1'b1; key_down = 1'b1;
      repeat (30) @(negedge clk);
      model_step(r, m, u, d, chg);
      check({tag, "_pulses"}, pulses - p0, chg ? 1 : 0);
      compare_all(tag);
   endtask

   initial begin
      int  p0, nrep;
      bit  chg;
      logic [3:0] mask;

      // Reset state, checked while reset is still asserted and after idle time
      model_reset();
      repeat (2) @(negedge clk);
      compare_all("in_reset");
      check("in_reset_chg", int'(param_chg), 0);
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1;
      p0 = pulses;
      repeat (50) @(negedge clk);
      check("idle_pulses", pulses - p0, 0);
      compare_all("idle");

      // Bouncing key accepted exactly once
      p0 = pulses;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         key_up = 1'b0; @(negedge clk);
         key_up = 1'b1; @(negedge clk);
      end
      key_up = 1'b0;
      repeat (30) @(negedge clk);
      key_up = 1'b1;
      repeat (30) @(negedge clk);
      model_step(0, 0, 1, 0, chg);
      check("bounce_pulses", pulses - p0, 1);
      check("bounce_level", int'(trig_level), 131);
      compare_all("bounce");

      // Level saturation at both ends: down to 0, up to 252, then 255 and stuck
      do_reset(0);
      for (int i = 0; i < 32; i++) do_press(0, 0, 0, 1, 25, "lvl_dn");
      check("lvl_zero", int'(trig_level), 0);
      for (int i = 0; i < 63; i++) do_press(0, 0, 1, 0, 25, "lvl_up");
      check("lvl_252", int'(trig_level), 252);
      do_press(0, 0, 1, 0, 25, "lvl_255");
      check("lvl_255_val", int'(trig_level), 255);
      do_press(0, 0, 1, 0, 25, "lvl_sat");
      check("lvl_sat_val", int'(trig_level), 255);

      // Mode walk and wrap
      do_reset(0);
      for (int i = 1; i <= 4; i++) begin
         do_press(0, 1, 0, 0, 30, "mode");
         check("mode_seq", int'(sel_mode), i % 4);
      end

      // Decimation floor and doubling
      do_reset(0);
      do_press(0, 1, 0, 0, 30, "to_deci");
      do_press(0, 1, 0, 0, 30, "to_deci");
      do_press(0, 0, 0, 1, 30, "deci_floor");
      check("deci_floor_val", int'(deci_rate), 1);
      for (int i = 0; i < 3; i++) do_press(0, 0, 1, 0, 30, "deci_up");
      check("deci_8", int'(deci_rate), 8);

      // V-scale step down from reset index
      do_reset(0);
      for (int i = 0; i < 3; i++) do_press(0, 1, 0, 0, 30, "to_vs");
      do_press(0, 0, 0, 1, 30, "vs_dn");
      check("vs_dn_val", int'(v_scale), 17);

      // Simultaneous up/down ignored; run toggles
      do_reset(0);
      do_press(0, 0, 1, 1, 30, "updn");
      check("updn_level", int'(trig_level), 127);
      do_press(1, 0, 0, 0, 30, "run");
      check("run_val", int'(wave_run), 0);

      // Key held through reset release must not fire until re-pressed
      key_up = 1'b0;
      do_reset(1);
      p0 = pulses;
      repeat (40) @(negedge clk);
      check("held_rst_level", int'(trig_level), 127);
      check("held_rst_pulses", pulses - p0, 0);
      key_up = 1'b1;
      repeat (30) @(negedge clk);
      do_press(0, 0, 1, 0, 30, "repress");
      check("repress_level", int'(trig_level), 131);

      // Long hold: repeats only when auto-repeat is built in
      do_reset(0);
      p0 = pulses;
      @(negedge clk);
      key_up = 1'b0;
      repeat (650) @(negedge clk);
      key_up = 1'b1;
      repeat (30) @(negedge clk);
`ifdef DSO_UI_AUTOREPEAT_EN
      nrep = 4;
`else
      nrep = 1;
`endif
      for (int i = 0; i < nrep; i++) model_step(0, 0, 1, 0, chg);
      check("hold_pulses", pulses - p0, nrep);
      check("hold_level", int'(trig_level), 127 + 4 * nrep);
      compare_all("hold");

      // Randomized key combinations against the model
      do_reset(0);
      for (int i = 0; i < 80; i++) begin
         mask = 4'($urandom_range(1, 15));
         do_press(mask[0], mask[1], mask[2], mask[3], int'($urandom_range(25, 60)), "rnd");
      end

      mon_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1);
   end

endmodule
